// File: rtl/addsub16_acc.sv
// Registered, handshaked 16-bit add/subtract front end with an accumulator, a sticky overflow
// flag and a completed-result counter. S1 holds operands and S2 holds the result.
module addsub16_acc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             sticky_ovf,
  output logic [WIDTH-1:0] acc_q,
  output logic [CNT_W-1:0] res_cnt
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_sub_q;
  logic             s1_acc_q;
  logic             s2_valid_q;

  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   full_sum;
  logic             ovf;

  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  // Held low during reset so every output reads 0 while rst_n is asserted.
  assign in_ready = rst_n && (!s1_valid_q || s1_adv);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;
  assign out_valid = s2_valid_q;

  always_comb begin
    op_a     = s1_acc_q ? acc_q : s1_a_q;
    op_b     = s1_sub_q ? ~s1_b_q : s1_b_q;
    full_sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, s1_sub_q};
    ovf      = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (full_sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  // Operand stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_sub_q   <= 1'b0;
      s1_acc_q   <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= in_a;
      s1_b_q     <= in_b;
      s1_sub_q   <= in_sub;
      s1_acc_q   <= in_acc;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Result stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      out_sum    <= '0;
      out_cout   <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      out_sum    <= full_sum[WIDTH-1:0];
      out_cout   <= full_sum[WIDTH];
      out_ovf    <= ovf;
    end else if (out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Accumulator, sticky flag and counter; clr wins over any same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      sticky_ovf <= 1'b0;
      res_cnt    <= '0;
    end else if (clr) begin
      acc_q      <= '0;
      sticky_ovf <= 1'b0;
      res_cnt    <= '0;
    end else begin
      if (s1_adv) begin
        acc_q <= full_sum[WIDTH-1:0];
        if (ovf) sticky_ovf <= 1'b1;
      end
      if (out_fire) res_cnt <= res_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_addsub16_acc.sv
// Directed bench for addsub16_acc; inputs driven and outputs sampled on the falling clock edge.
module tb_addsub16_acc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        in_acc;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        sticky_ovf;
  logic [15:0] acc_q;
  logic [15:0] res_cnt;

  int n_vec;
  int n_err;

  addsub16_acc #(
    .WIDTH(16),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_acc    (in_acc),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .sticky_ovf(sticky_ovf),
    .acc_q     (acc_q),
    .res_cnt   (res_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_acc   = acc;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] sum, input logic cout,
                         input logic ovf);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".sum"}, 32'(out_sum), 32'(sum));
    check({tag, ".cout"}, 32'(out_cout), 32'(cout));
    check({tag, ".ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_acc    = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.in_ready", 32'(in_ready), 0);
    check("rst.sum", 32'(out_sum), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rel.in_ready", 32'(in_ready), 1);
    check("rel.acc", 32'(acc_q), 0);
    check("rel.cnt", 32'(res_cnt), 0);
    check("rel.sticky", 32'(sticky_ovf), 0);
    tick();

    // Signed overflow on add
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk_res("add_ovf", 16'h8000, 1'b0, 1'b1);
    check("add_ovf.sticky", 32'(sticky_ovf), 1);

    // Subtract with borrow, then signed overflow on subtract
    drive(16'h0000, 16'h0001, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk_res("sub_borrow", 16'hFFFF, 1'b0, 1'b0);
    drive(16'h8000, 16'h0001, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1);

    // Clear coincides with the final result being consumed: counter must still read 0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr.acc", 32'(acc_q), 0);
    check("clr.cnt", 32'(res_cnt), 0);
    check("clr.sticky", 32'(sticky_ovf), 0);

    // Back-to-back accumulate chain; in_a carries junk that must be ignored
    drive(16'h1234, 16'd5, 1'b0, 1'b1);
    check("chain.rdy0", 32'(in_ready), 1);
    tick();
    check("chain.rdy1", 32'(in_ready), 1);
    drive(16'h4321, 16'd3, 1'b0, 1'b1);
    tick();
    check("chain.rdy2", 32'(in_ready), 1);
    chk_res("chain0", 16'h0005, 1'b0, 1'b0);
    drive(16'hBEEF, 16'd10, 1'b1, 1'b1);
    tick();
    in_valid = 1'b0;
    chk_res("chain1", 16'h0008, 1'b0, 1'b0);
    tick();
    chk_res("chain2", 16'hFFFE, 1'b0, 1'b0);
    check("chain.acc", 32'(acc_q), 32'hFFFE);
    tick();
    check("chain.cnt", 32'(res_cnt), 3);
    check("chain.drain", 32'(out_valid), 0);

    // Backpressure: two accepted, third stalls, then results drain in order
    out_ready = 1'b0;
    drive(16'd1, 16'd1, 1'b0, 1'b0);
    tick();
    check("bp.rdy1", 32'(in_ready), 1);
    drive(16'd2, 16'd2, 1'b0, 1'b0);
    tick();
    drive(16'd3, 16'd3, 1'b0, 1'b0);
    #1;
    check("bp.rdy_drop", 32'(in_ready), 0);
    tick();
    check("bp.rdy_hold", 32'(in_ready), 0);
    chk_res("bp.hold0", 16'd2, 1'b0, 1'b0);
    tick();
    chk_res("bp.hold1", 16'd2, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    check("bp.rdy_rel", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk_res("bp.out1", 16'd4, 1'b0, 1'b0);
    tick();
    chk_res("bp.out2", 16'd6, 1'b0, 1'b0);
    tick();
    check("bp.drain", 32'(out_valid), 0);
    check("bp.cnt", 32'(res_cnt), 6);

    // clr on the same edge as an overflowing S1 advance
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    check("clrcol.sticky", 32'(sticky_ovf), 0);
    check("clrcol.acc", 32'(acc_q), 0);
    check("clrcol.cnt", 32'(res_cnt), 0);
    chk_res("clrcol.res", 16'h8000, 1'b0, 1'b1);
    tick();
    check("clrcol.cnt1", 32'(res_cnt), 1);

    // Async reset with both stages full
    out_ready = 1'b0;
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    tick();
    drive(16'h0010, 16'h0020, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("ar.pre_valid", 32'(out_valid), 1);
    check("ar.pre_sticky", 32'(sticky_ovf), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar.valid", 32'(out_valid), 0);
    check("ar.sum", 32'(out_sum), 0);
    check("ar.ovf", 32'(out_ovf), 0);
    check("ar.acc", 32'(acc_q), 0);
    check("ar.sticky", 32'(sticky_ovf), 0);
    check("ar.cnt", 32'(res_cnt), 0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_a      = 16'hAAAA;
    tick();
    check("ar.no_stale", 32'(out_valid), 0);
    in_a = 16'h5555;
    tick();
    check("ar.idle", 32'(out_valid), 0);
    drive(16'h0001, 16'h0002, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk_res("ar.first", 16'h0003, 1'b0, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub16_acc.md
Name: addsub16_acc

Overview:
- Registered, handshaked front end around the team's 16-bit add/subtract datapath.
- Accepts operation requests (A, B, add/sub, accumulate-select), computes A+B or A-B with carry and signed overflow, and presents registered results downstream.
- Keeps an internal accumulator so chained operations can use the previous result as operand A.
- Also keeps a sticky overflow flag and a count of completed results.

Parameters:
- WIDTH, 16, operand/result width; flag and overflow rules below assume two's complement at this width.
- CNT_W, 16, width of the completed-result counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request this cycle
- in_a  input  WIDTH  operand A (ignored when in_acc=1)
- in_b  input  WIDTH  operand B
- in_sub  input  1  0 = A+B, 1 = A-B
- in_acc  input  1  1 = use accumulator as operand A
- clr  input  1  synchronous clear of accumulator, sticky flag and counter
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of MSB
- out_ovf  output  1  signed overflow of this result
- sticky_ovf  output  1  OR of out_ovf over all results since reset/clr
- acc_q  output  WIDTH  current accumulator value
- res_cnt  output  CNT_W  results accepted downstream since reset/clr

Behaviour:
- Reset (async, rst_n=0): every register and output goes to 0 immediately. This covers s1_valid, s2_valid, out_sum, out_cout, out_ovf, acc_q, sticky_ovf and res_cnt. in_ready=1 once rst_n deasserts.
- Pipeline structure: S1 is the operand register; S2 is the result register.
- Request transfer: occurs when in_valid && in_ready. Operands, op and acc-select are captured into S1.
- S1 advance: when s1_valid && (!s2_valid || out_ready), the combinational result of S1 is loaded into S2 and s2_valid=1.
- in_ready = !s1_valid || S1 advancing this cycle. Gives full throughput, one op per cycle, with no combinational path from in_valid to in_ready.
- Latency: a request accepted at edge N appears on out_* after edge N+1 when there is no backpressure.
- Output hold: out_* stay stable while out_valid && !out_ready. s2_valid clears when out_ready is high and S1 is not advancing.
- Operand A: equals acc_q sampled while the op sits in S1 when in_acc=1, otherwise in_a.
- Add: sum = A+B; cout = bit WIDTH of the (WIDTH+1)-bit sum.
- Subtract: sum = A + ~B + 1; cout = carry out, so 1 means no borrow.
- Overflow: ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' = B for add and ~B for subtract.
- Accumulator update: acc_q <= S1 sum on every S1 advance, whether or not the op used in_acc.
  - A back-to-back accumulate op entering S1 on the same edge sees the updated acc_q next cycle, so there is no hazard and no stall.
- Sticky flag: set on an S1 advance whose ovf=1.
- Counter: res_cnt increments on each out_valid && out_ready and wraps from all-ones to 0.
- clr: zeroes acc_q, sticky_ovf and res_cnt on the next edge.
  - clr has priority over a simultaneous acc update, sticky set or count increment.
  - clr does not flush S1/S2; pending results still emit unchanged.
- Reset mid-operation: in-flight S1/S2 contents are discarded and no out_valid is produced for them.
- in_valid low: no S1 load, even if the input data changes.

Test Plan:
- Add, signed overflow: a=0x7FFF, b=0x0001, sub=0, out_ready=1 -> two cycles later sum=0x8000, cout=0, ovf=1, sticky_ovf=1.
- Subtract, borrow: 0x0000-0x0001 -> sum=0xFFFF, cout=0, ovf=0. Then 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Accumulate chain: pulse clr, then back-to-back in_acc=1 ops add 5, add 3, sub 10 -> sums 0x0005, 0x0008, 0xFFFE; acc_q=0xFFFE; res_cnt=3; no in_ready drop.
- Backpressure: hold out_ready=0 and issue 3 requests -> in_ready drops after 2 accepts, out_* stable. Release -> results emerge in order, one per cycle, none lost or duplicated.
- clr collision: assert clr on the same edge as an overflowing S1 advance -> sticky_ovf=0, acc_q=0, res_cnt=0. The pending result is still emitted with ovf=1.
- Async reset mid-stream: drop rst_n between edges with S1/S2 full -> all outputs 0 at once, no stale out_valid after release. First new op 0x0001+0x0002 -> 0x0003.
